aes_fault_scheduler: RTL
========================

AES_FAULT_SCHEDULER -- requirements
Module: aes_fault_scheduler

Interface
REQ-001 Parameter NUM_REQ, 2, number of requesters sharing one hardened AES engine (2..8).
REQ-002 Parameter MAX_RETRY, 2, re-encryptions allowed per job after fault_alert.
REQ-003 Parameter LOCK_THRESH, 4, cumulative faults that force lockout.
REQ-004 Parameter TIMEOUT_CYC, 64, WAIT-state cycle budget per attempt.
REQ-005 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 Port req_valid, input, NUM_REQ, per-requester job request.
REQ-008 Port req_ready, output, NUM_REQ, one-hot one-cycle accept pulse.
REQ-009 Port req_pt / req_key, input, NUM_REQ*128 each, packed plaintext/key, slot i at [128*i +: 128].
REQ-010 Port rsp_valid, output, NUM_REQ, one-hot one-cycle response pulse.
REQ-011 Port rsp_ct / rsp_err, output, 128 / 1, result ciphertext and failure flag.
REQ-012 Port aes_start / aes_plaintext / aes_key, output, 1/128/128, engine launch.
REQ-013 Port aes_ciphertext / aes_valid / aes_busy / aes_fault_alert, input, 128/1/1/1, engine result.
REQ-014 Port clear_lockout, input, 1, software release of lockout.
REQ-015 Port lockout / fault_count, output, 1 / 8, lock state and saturating fault tally.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, RESP, LOCK.
REQ-017 IDLE: any req_valid -> round-robin grant starting at last_grant+1 (mod NUM_REQ); pulse req_ready[grant]; latch pt/key; clear retry count and timer; -> LAUNCH next cycle.
REQ-018 LAUNCH: hold while aes_busy=1; else assert aes_start one cycle with latched operands -> WAIT.
REQ-019 aes_plaintext/aes_key SHALL be stable from LAUNCH entry until leaving WAIT.
REQ-020 WAIT: aes_fault_alert=1 -> increment fault_count (saturate 255); if retry<MAX_RETRY, retry+1 -> LAUNCH, else rsp_err=1 -> RESP.
REQ-021 WAIT: aes_valid=1 with no fault -> latch aes_ciphertext into rsp_ct, rsp_err=0 -> RESP.
REQ-022 aes_fault_alert and aes_valid in the same cycle: fault wins.
REQ-023 RESP: rsp_valid[grant]=1 for exactly one cycle; rsp_ct held until next RESP; then -> LOCK if fault_count>=LOCK_THRESH else IDLE.
REQ-024 On any rsp_err, rsp_ct SHALL be forced to zero (no faulty ciphertext leak).
REQ-025 LOCK: lockout=1, no grants; clear_lockout=1 -> fault_count=0, -> IDLE.
REQ-026 clear_lockout outside LOCK SHALL be ignored.
REQ-027 Minimum fault-free job latency: accept-to-rsp_valid = 3 cycles + engine latency.
REQ-028 Requests arriving outside IDLE wait; req_valid must hold until req_ready.

Reset
REQ-029 rst_n=0 at a clock edge -> state IDLE, last_grant=NUM_REQ-1, all outputs 0, fault_count=0, operand/result registers 0.
REQ-030 Reset mid-job SHALL abandon the job without any rsp_valid.

Configuration
REQ-031 Macro AES_SCHED_TIMEOUT_EN defined: WAIT counter; TIMEOUT_CYC cycles without aes_valid/aes_fault_alert is treated as a fault (REQ-020 path, counts toward fault_count).
REQ-032 Macro AES_SCHED_TIMEOUT_EN undefined: no timer logic; WAIT waits indefinitely.

Structure
REQ-033 Shared package aes_sched_pkg SHALL hold the FSM state enum, 128-bit block typedef, and default parameter constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_REQ request vector + last_grant -> one-hot grant).
REQ-035 Implementation target 150-300 lines RTL.

Verification
REQ-036 req_valid=2'b11 held for four jobs, clean engine -> grants alternate 0,1,0,1; each rsp_err=0, rsp_ct=engine output (FIPS-197: key 000102..0f, pt 00112233..ff -> 69c4e0d86a7b0430d8cdb78070b4c55a).
REQ-037 One fault_alert on first attempt -> exactly two aes_start pulses, rsp_err=0, fault_count=1.
REQ-038 fault_alert on all 3 attempts (MAX_RETRY=2) -> rsp_err=1, rsp_ct=0, fault_count=3.
REQ-039 Faults until fault_count=4 -> lockout=1 after RESP, req_valid ignored; clear_lockout pulse -> lockout=0, fault_count=0, next request granted.
REQ-040 With AES_SCHED_TIMEOUT_EN, engine silent for 64 cycles -> counted as fault and retried; rst_n=0 during WAIT -> no rsp_valid, all outputs 0 next cycle.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and default parameters for the AES fault-aware job scheduler.
package aes_sched_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP,
    ST_LOCK
  } state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_MAX_RETRY   = 2;
  localparam int DEF_LOCK_THRESH = 4;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int FAULT_CNT_W     = 8;

endpackage

// File: rtl/aes_fault_scheduler_if.sv
// Bus between the scheduler (master) and the hardened AES engine (slave).
interface aes_fault_scheduler_if import aes_sched_pkg::*; ();

  logic   aes_start;
  block_t aes_plaintext;
  block_t aes_key;
  block_t aes_ciphertext;
  logic   aes_valid;
  logic   aes_busy;
  logic   aes_fault_alert;

  modport master (
    output aes_start, aes_plaintext, aes_key,
    input  aes_ciphertext, aes_valid, aes_busy, aes_fault_alert
  );

  modport slave (
    input  aes_start, aes_plaintext, aes_key,
    output aes_ciphertext, aes_valid, aes_busy, aes_fault_alert
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the previous winner and wraps.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_fault_scheduler.sv
// Shares one hardened AES engine between NUM_REQ requesters with fault retry and lockout.
// Optional WAIT watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_fault_scheduler import aes_sched_pkg::*; #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_pt,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output block_t                 rsp_ct,
  output logic                   rsp_err,
  aes_fault_scheduler_if.master  aes,
  input  logic                   clear_lockout,
  output logic                   lockout,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        last_q, last_d;
  block_t                 pt_q, pt_d, key_q, key_d, ct_q, ct_d;
  logic                   err_q, err_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDXW-1:0]    grant_idx;
  logic               timeout;
  logic               fault_ev;
  logic               can_retry;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDXW'(i);
    end
  end

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;

  // Timer only runs in WAIT, so it restarts from zero for every attempt.
  always_comb begin
    timer_d = '0;
    timeout = 1'b0;
    if (state_q == ST_WAIT && !aes.aes_valid && !aes.aes_fault_alert) begin
      if (timer_q == TW'(TIMEOUT_CYC - 1)) timeout = 1'b1;
      else                                 timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  always_comb timeout = 1'b0;
`endif

  // Fault alert takes precedence over a simultaneous aes_valid.
  assign fault_ev  = (state_q == ST_WAIT) && (aes.aes_fault_alert || timeout);
  assign can_retry = retry_q < RW'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDXW'(NUM_REQ - 1);
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|req_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: if (!aes.aes_busy) state_d = ST_WAIT;
      ST_WAIT: begin
        if (fault_ev)           state_d = can_retry ? ST_LAUNCH : ST_RESP;
        else if (aes.aes_valid) state_d = ST_RESP;
      end
      ST_RESP:   state_d = (fcnt_q >= FAULT_CNT_W'(LOCK_THRESH)) ? ST_LOCK : ST_IDLE;
      ST_LOCK:   if (clear_lockout) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
    err_d   = err_q;
    retry_d = retry_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          last_d  = grant_idx;
          pt_d    = req_pt[128*grant_idx +: 128];
          key_d   = req_key[128*grant_idx +: 128];
          retry_d = '0;
        end
      end
      ST_WAIT: begin
        if (fault_ev) begin
          if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
          if (can_retry) begin
            retry_d = retry_q + 1'b1;
          end else begin
            ct_d  = '0;
            err_d = 1'b1;
          end
        end else if (aes.aes_valid) begin
          ct_d  = aes.aes_ciphertext;
          err_d = 1'b0;
        end
      end
      ST_LOCK: if (clear_lockout) fcnt_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    req_ready         = (state_q == ST_IDLE) ? grant : '0;
    rsp_valid         = (state_q == ST_RESP) ? (NUM_REQ'(1) << last_q) : '0;
    rsp_ct            = ct_q;
    rsp_err           = err_q;
    lockout           = (state_q == ST_LOCK);
    fault_count       = fcnt_q;
    aes.aes_start     = (state_q == ST_LAUNCH) && !aes.aes_busy;
    aes.aes_plaintext = pt_q;
    aes.aes_key       = key_q;
  end

endmodule
